ifetch_unit: RTL

- Multicycle-CPU instruction fetch initiator. It owns the PC and drives the instruction memory read interface (address, read strobe, write strobe, write data, read data).
- On a controller request it reads the word at PC, latches it into IR and reports completion.
- Between fetches it applies sequential, branch, jump or jump-register PC updates commanded by the controller.

---
 rtl/ifetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Multicycle-CPU instruction fetch initiator: owns the PC, reads IM into IR on request.
// Optional build macro IFETCH_COUNT_EN adds a free-running completed-fetch counter output.
module ifetch_unit #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_update,
    input  logic [1:0]  next_pc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_data,
    output logic [31:0] im_addr,
    output logic        im_r,
    output logic        im_w,
    output logic [31:0] im_wd,
    input  logic [31:0] im_rd,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic        fetch_done,
    output logic        busy,
    output logic        misalign
`ifdef IFETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        done_q, done_d;
    logic        mis_q, mis_d;
    logic [31:0] next_pc_s;
    logic [31:0] branch_off_s;

    assign pc_plus4     = pc_q + 32'd4;
    assign branch_off_s = {{14{imm16[15]}}, imm16, 2'b00};

    // Next-PC selection for a controller-commanded update
    always_comb begin
        next_pc_s = pc_plus4;
        case (next_pc_sel)
            2'b00:   next_pc_s = pc_plus4;
            2'b01:   next_pc_s = branch_taken ? (pc_plus4 + branch_off_s) : pc_plus4;
            2'b10:   next_pc_s = {pc_plus4[31:28], target26, 2'b00};
            2'b11:   next_pc_s = {rs_data[31:2], 2'b00};
            default: next_pc_s = pc_plus4;
        endcase
    end

    // Fetch sequencing; a same-cycle update+fetch is remembered in pend so no fetch is lost
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        done_d  = 1'b0;
        mis_d   = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (pc_update) begin
                    pc_d   = next_pc_s;
                    pend_d = pend_q | fetch_req;
                    if ((next_pc_sel == 2'b11) && (rs_data[1:0] != 2'b00)) begin
                        mis_d = 1'b1;
                    end else begin
                        mis_d = mis_q;
                    end
                end else if (fetch_req || pend_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    ir_d    = im_rd;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            pc_q    <= PC_RESET;
            ir_q    <= 32'd0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
        end
    end

`ifdef IFETCH_COUNT_EN
    logic [31:0] fcnt_q, fcnt_d;

    assign fcnt_d      = done_q ? (fcnt_q + 32'd1) : fcnt_q;
    assign fetch_count = fcnt_q;

    // Completed-fetch counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 32'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end
`endif

    assign im_r       = (state_q == ST_WAIT);
    assign busy       = (state_q == ST_WAIT);
    assign im_addr    = {pc_q[31:2], 2'b00};
    assign im_w       = 1'b0;
    assign im_wd      = 32'd0;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign fetch_done = done_q;
    assign misalign   = mis_q;

endmodule
